// File: rtl/alu_sequencer.sv
// Sequences high-level ALU ops (ADD/SUB/AND/OR/XOR/NOT/CMPEQ/MUL) onto a minimal ADD/NAND/PASS1/EQ ALU.
// Compile-time option: define ALU_SEQ_MUL_EN to enable op 7 (MUL by 16-iteration shift-add).
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_flag,
    output logic [1:0]  alu_func,
    output logic [15:0] alu_operand1,
    output logic [15:0] alu_operand2,
    input  logic [15:0] alu_result,
    input  logic        alu_eq
);

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 6;

    localparam logic [1:0] F_ADD   = 2'b00;
    localparam logic [1:0] F_NAND  = 2'b01;
    localparam logic [1:0] F_PASS1 = 2'b10;
    localparam logic [1:0] F_EQ    = 2'b11;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_NOT   = 3'd5;
    localparam logic [2:0] OP_CMPEQ = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t          r_state;
    logic [2:0]      r_op;
    logic [DW-1:0]   r_a, r_b, r_t1, r_t2;
    logic [SW-1:0]   r_step;
    logic            r_req_ready, r_rsp_valid, r_rsp_flag;
    logic [DW-1:0]   r_rsp_data;
    logic [1:0]      r_func;
    logic [DW-1:0]   r_op1, r_op2;

    logic [2:0]      w_op;
    logic [DW-1:0]   w_a, w_b, w_t1_nxt, w_t2_nxt;
    logic [SW-1:0]   w_step_nxt, w_k;
    logic            w_last;
    logic [1:0]      w_func;
    logic [DW-1:0]   w_op1, w_op2;

    // Number of ALU steps each op needs
    function automatic logic [SW-1:0] op_steps(input logic [2:0] op);
        case (op)
            OP_ADD, OP_NOT, OP_CMPEQ: op_steps = SW'(1);
            OP_AND:                   op_steps = SW'(2);
            OP_SUB, OP_OR:            op_steps = SW'(3);
            OP_XOR:                   op_steps = SW'(4);
`ifdef ALU_SEQ_MUL_EN
            default:                  op_steps = SW'(32);
`else
            default:                  op_steps = SW'(0);
`endif
        endcase
    endfunction

    assign w_op       = (r_state == S_IDLE) ? req_op : r_op;
    assign w_a        = (r_state == S_IDLE) ? req_a  : r_a;
    assign w_b        = (r_state == S_IDLE) ? req_b  : r_b;
    assign w_step_nxt = (r_state == S_IDLE) ? SW'(0) : r_step + SW'(1);
    assign w_k        = op_steps(r_op);
    assign w_last     = (w_k == SW'(0)) || (r_step == w_k - SW'(1));

    // Capture the result of the step just executed into the temporaries
    always_comb begin
        w_t1_nxt = r_t1;
        w_t2_nxt = r_t2;
        if (r_state == S_IDLE) begin
            w_t1_nxt = '0;
            w_t2_nxt = (req_op == OP_MUL) ? req_a : '0;
        end else if (r_state == S_EXEC) begin
            case (r_op)
                OP_CMPEQ: ;
                OP_OR, OP_XOR: begin
                    if (r_step == SW'(1)) w_t2_nxt = alu_result;
                    else                  w_t1_nxt = alu_result;
                end
                OP_MUL: begin
`ifdef ALU_SEQ_MUL_EN
                    if (r_step[0])              w_t2_nxt = alu_result;
                    else if (r_b[r_step[4:1]])  w_t1_nxt = alu_result;
`endif
                end
                default: w_t1_nxt = alu_result;
            endcase
        end
    end

    // ALU command for the upcoming step
    always_comb begin
        w_func = F_PASS1;
        w_op1  = '0;
        w_op2  = '0;
        case (w_op)
            OP_ADD: begin w_func = F_ADD; w_op1 = w_a; w_op2 = w_b; end
            OP_SUB: begin
                case (w_step_nxt)
                    SW'(0):  begin w_func = F_NAND; w_op1 = w_b;      w_op2 = w_b;      end
                    SW'(1):  begin w_func = F_ADD;  w_op1 = w_t1_nxt; w_op2 = DW'(1);   end
                    default: begin w_func = F_ADD;  w_op1 = w_a;      w_op2 = w_t1_nxt; end
                endcase
            end
            OP_AND: begin
                w_func = F_NAND;
                w_op1  = (w_step_nxt == SW'(0)) ? w_a : w_t1_nxt;
                w_op2  = (w_step_nxt == SW'(0)) ? w_b : w_t1_nxt;
            end
            OP_OR: begin
                w_func = F_NAND;
                case (w_step_nxt)
                    SW'(0):  begin w_op1 = w_a;      w_op2 = w_a;      end
                    SW'(1):  begin w_op1 = w_b;      w_op2 = w_b;      end
                    default: begin w_op1 = w_t1_nxt; w_op2 = w_t2_nxt; end
                endcase
            end
            OP_XOR: begin
                w_func = F_NAND;
                case (w_step_nxt)
                    SW'(0):  begin w_op1 = w_a;      w_op2 = w_b;      end
                    SW'(1):  begin w_op1 = w_a;      w_op2 = w_t1_nxt; end
                    SW'(2):  begin w_op1 = w_b;      w_op2 = w_t1_nxt; end
                    default: begin w_op1 = w_t2_nxt; w_op2 = w_t1_nxt; end
                endcase
            end
            OP_NOT:   begin w_func = F_NAND; w_op1 = w_a; w_op2 = w_a; end
            OP_CMPEQ: begin w_func = F_EQ;   w_op1 = w_a; w_op2 = w_b; end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                // Even steps accumulate (PASS1 idle for a zero bit), odd steps double m
                if (w_step_nxt[0]) begin
                    w_func = F_ADD; w_op1 = w_t2_nxt; w_op2 = w_t2_nxt;
                end else if (w_b[w_step_nxt[4:1]]) begin
                    w_func = F_ADD; w_op1 = w_t1_nxt; w_op2 = w_t2_nxt;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_t1        <= '0;
            r_t2        <= '0;
            r_step      <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flag  <= 1'b0;
            r_func      <= F_PASS1;
            r_op1       <= '0;
            r_op2       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state     <= S_EXEC;
                        r_op        <= req_op;
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_t1        <= w_t1_nxt;
                        r_t2        <= w_t2_nxt;
                        r_step      <= '0;
                        r_req_ready <= 1'b0;
                        r_func      <= w_func;
                        r_op1       <= w_op1;
                        r_op2       <= w_op2;
                    end
                end
                S_EXEC: begin
                    r_t1 <= w_t1_nxt;
                    r_t2 <= w_t2_nxt;
                    if (w_last) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_step      <= '0;
                        r_func      <= F_PASS1;
                        r_op1       <= '0;
                        r_op2       <= '0;
                        case (r_op)
                            OP_CMPEQ: begin r_rsp_data <= '0; r_rsp_flag <= alu_eq; end
`ifdef ALU_SEQ_MUL_EN
                            OP_MUL:   begin r_rsp_data <= w_t1_nxt; r_rsp_flag <= 1'b0; end
`else
                            OP_MUL:   begin r_rsp_data <= '0; r_rsp_flag <= 1'b1; end
`endif
                            default:  begin r_rsp_data <= alu_result; r_rsp_flag <= 1'b0; end
                        endcase
                    end else begin
                        r_step <= w_step_nxt;
                        r_func <= w_func;
                        r_op1  <= w_op1;
                        r_op2  <= w_op2;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_flag     = r_rsp_flag;
    assign alu_func     = r_func;
    assign alu_operand1 = r_op1;
    assign alu_operand2 = r_op2;

endmodule
